// File: rtl/ex_stage_pipe.sv
// Registered execute stage: operand select, single-cycle ALU, optional iterative
// multiply, and a valid/ready EX/MEM output register.
module ex_stage_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned MUL_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data1,
   input  logic [WIDTH-1:0]  in_data2,
   input  logic [3:0]        in_alu_op,
   input  logic [2:0]        in_sel_a,
   input  logic [2:0]        in_sel_b,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [REG_AW-1:0] in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_alu,
   output logic [WIDTH-1:0]  out_mem_addr,
   output logic [WIDTH-1:0]  out_store_data,
   output logic [REG_AW-1:0] out_dest,
   output logic              busy
);

   localparam int unsigned SHW = $clog2(WIDTH);

   localparam logic [3:0] OpAdd   = 4'd0;
   localparam logic [3:0] OpSub   = 4'd1;
   localparam logic [3:0] OpAnd   = 4'd2;
   localparam logic [3:0] OpOr    = 4'd3;
   localparam logic [3:0] OpXor   = 4'd4;
   localparam logic [3:0] OpNor   = 4'd5;
   localparam logic [3:0] OpSlt   = 4'd6;
   localparam logic [3:0] OpSltu  = 4'd7;
   localparam logic [3:0] OpSll   = 4'd8;
   localparam logic [3:0] OpSrl   = 4'd9;
   localparam logic [3:0] OpSra   = 4'd10;
   localparam logic [3:0] OpPassb = 4'd11;
   localparam logic [3:0] OpMul   = 4'd12;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] imm_zext, imm_sext, imm_upper;
   logic [WIDTH-1:0] op_a, op_b;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] mem_addr;
   logic             is_mul;
   logic             accept;
   logic             done_load;

   // Multiply working state plus the instruction fields it retires with
   logic [WIDTH-1:0]  mcand_q, mplier_q, prod_q;
   logic [SHW-1:0]    cnt_q;
   logic [REG_AW-1:0] m_dest_q;
   logic [WIDTH-1:0]  m_addr_q, m_store_q;

   assign imm_zext  = {{(WIDTH-IMM_W){1'b0}}, in_imm};
   assign imm_sext  = {{(WIDTH-IMM_W){in_imm[IMM_W-1]}}, in_imm};
   assign imm_upper = {in_imm, {(WIDTH-IMM_W){1'b0}}};

   always_comb begin
      op_a = '0;
      if (in_sel_a == 3'd0) begin
         op_a = in_data1;
      end
   end

   always_comb begin
      op_b = '0;
      case (in_sel_b)
         3'd0:    op_b = in_data2;
         3'd1:    op_b = imm_zext;
         3'd2:    op_b = imm_sext;
         3'd3:    op_b = imm_upper;
         default: op_b = '0;
      endcase
   end

   assign shamt    = op_b[SHW-1:0];
   assign mem_addr = in_data1 + imm_sext;

   always_comb begin
      alu_res = '0;
      case (in_alu_op)
         OpAdd:   alu_res = op_a + op_b;
         OpSub:   alu_res = op_a - op_b;
         OpAnd:   alu_res = op_a & op_b;
         OpOr:    alu_res = op_a | op_b;
         OpXor:   alu_res = op_a ^ op_b;
         OpNor:   alu_res = ~(op_a | op_b);
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OpSll:   alu_res = op_a << shamt;
         OpSrl:   alu_res = op_a >> shamt;
         OpSra:   alu_res = $signed(op_a) >>> shamt;
         OpPassb: alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   // With MUL_EN=0 op 12 falls through to the single-cycle path and yields zero
   assign is_mul   = (MUL_EN != 0) && (in_alu_op == OpMul);
   assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != StIdle);

   always_comb begin
      state_d   = state_q;
      done_load = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept && is_mul) begin
               state_d = StMul;
            end
         end
         StMul: begin
            if (cnt_q == SHW'(WIDTH-1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (!out_valid || out_ready) begin
               done_load = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // LSB-first shift-add; only the low WIDTH bits of the product are kept
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         m_dest_q  <= '0;
         m_addr_q  <= '0;
         m_store_q <= '0;
      end else if (state_q == StIdle && accept && is_mul) begin
         mcand_q   <= op_a;
         mplier_q  <= op_b;
         prod_q    <= '0;
         cnt_q     <= '0;
         m_dest_q  <= in_dest;
         m_addr_q  <= mem_addr;
         m_store_q <= in_data2;
      end else if (state_q == StMul) begin
         if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_alu        <= '0;
         out_mem_addr   <= '0;
         out_store_data <= '0;
         out_dest       <= '0;
      end else if (accept && !is_mul) begin
         out_valid      <= 1'b1;
         out_alu        <= alu_res;
         out_mem_addr   <= mem_addr;
         out_store_data <= in_data2;
         out_dest       <= in_dest;
      end else if (done_load) begin
         out_valid      <= 1'b1;
         out_alu        <= prod_q;
         out_mem_addr   <= m_addr_q;
         out_store_data <= m_store_q;
         out_dest       <= m_dest_q;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
